time_key_entry: RTL and testbench

- Keypad-side writer for the alarm clock's time-load interface.
- Collects BCD digit keys into a four-digit shift buffer (calculator style) and toggles AM/PM.
- Validates the buffered time when SET is pressed; on success, drives new_current_time_* with a one-cycle load_new_c pulse into counting_logic.
- Sits between the keypad scanner/debouncer and counting_logic.

---
 rtl/time_key_entry.sv | 129 ++++++++++++
 tb/tb_time_key_entry.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/time_key_entry.sv
// Keypad-side time entry: shifts BCD digit keys into a four-digit buffer, toggles AM/PM,
// validates on SET and issues a one-cycle load_new_c pulse with the new time to counting_logic.
module time_key_entry #(
  parameter int unsigned TWELVE_HOUR = 1,
  parameter int unsigned MIN_DIGITS  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key,
  output logic [3:0] new_current_time_ls_min,
  output logic [3:0] new_current_time_ms_min,
  output logic [3:0] new_current_time_ls_hr,
  output logic [3:0] new_current_time_ms_hr,
  output logic       new_current_time_AM,
  output logic       load_new_c,
  output logic       entry_error,
  output logic [2:0] digit_count
);

  localparam bit         Twelve    = (TWELVE_HOUR != 0);
  localparam logic [2:0] MinDigits = 3'(MIN_DIGITS);

  localparam logic [3:0] KeyAmPm  = 4'hA;
  localparam logic [3:0] KeySet   = 4'hB;
  localparam logic [3:0] KeyClear = 4'hC;

  typedef enum logic [1:0] {StIdle, StEntry, StLoad, StError} state_e;

  state_e     state_q;
  logic [3:0] ls_min_q, ms_min_q, ls_hr_q, ms_hr_q;
  logic       am_q, load_q, err_q;
  logic [2:0] count_q;

  logic [7:0] hour_val;
  logic       hour_ok;
  logic       set_ok;

  always_comb begin
    hour_val = {4'b0, ms_hr_q} * 8'd10 + {4'b0, ls_hr_q};
    if (Twelve) begin
      hour_ok = (hour_val >= 8'd1) && (hour_val <= 8'd12);
    end else begin
      hour_ok = (hour_val <= 8'd23);
    end
    set_ok = (count_q >= MinDigits) && (ls_min_q <= 4'd9) && (ms_min_q <= 4'd5) &&
             (ls_hr_q <= 4'd9) && (ms_hr_q <= 4'd9) && hour_ok;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      ls_min_q <= 4'd0;
      ms_min_q <= 4'd0;
      ls_hr_q  <= 4'd0;
      ms_hr_q  <= 4'd0;
      am_q     <= Twelve;
      load_q   <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= 3'd0;
    end else begin
      load_q <= 1'b0;
      if (state_q == StLoad) begin
        // Committed time stays on the outputs; any key arriving now is dropped.
        count_q <= 3'd0;
        state_q <= StIdle;
      end else if (key_valid) begin
        if (key <= 4'd9) begin
          if (state_q == StEntry) begin
            ms_hr_q  <= ls_hr_q;
            ls_hr_q  <= ms_min_q;
            ms_min_q <= ls_min_q;
            ls_min_q <= key;
            count_q  <= (count_q == 3'd4) ? 3'd4 : count_q + 3'd1;
          end else begin
            ms_hr_q  <= 4'd0;
            ls_hr_q  <= 4'd0;
            ms_min_q <= 4'd0;
            ls_min_q <= key;
            count_q  <= 3'd1;
          end
          err_q   <= 1'b0;
          state_q <= StEntry;
        end else begin
          case (key)
            KeyAmPm: begin
              if (Twelve) begin
                am_q <= ~am_q;
                if (state_q == StError) begin
                  err_q   <= 1'b0;
                  state_q <= StEntry;
                end
              end
            end
            KeySet: begin
              if ((state_q == StEntry) && set_ok) begin
                load_q  <= 1'b1;
                state_q <= StLoad;
              end else begin
                err_q   <= 1'b1;
                state_q <= StError;
              end
            end
            KeyClear: begin
              ls_min_q <= 4'd0;
              ms_min_q <= 4'd0;
              ls_hr_q  <= 4'd0;
              ms_hr_q  <= 4'd0;
              count_q  <= 3'd0;
              err_q    <= 1'b0;
              state_q  <= StIdle;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign new_current_time_ls_min = ls_min_q;
  assign new_current_time_ms_min = ms_min_q;
  assign new_current_time_ls_hr  = ls_hr_q;
  assign new_current_time_ms_hr  = ms_hr_q;
  assign new_current_time_AM     = am_q;
  assign load_new_c              = load_q;
  assign entry_error             = err_q;
  assign digit_count             = count_q;

endmodule

// File: tb/tb_time_key_entry.sv
// Bench for time_key_entry: 12-hour and 24-hour instances share stimulus and are compared
// every cycle against a behavioural model of the keypad entry rules.
module tb_time_key_entry;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key;

  logic [3:0] a_lsm, a_msm, a_lsh, a_msh;
  logic       a_am, a_load, a_err;
  logic [2:0] a_cnt;
  logic [3:0] b_lsm, b_msm, b_lsh, b_msh;
  logic       b_am, b_load, b_err;
  logic [2:0] b_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  time_key_entry #(.TWELVE_HOUR(1), .MIN_DIGITS(3)) u_dut12 (
    .clk                     (clk),
    .reset                   (reset),
    .key_valid               (key_valid),
    .key                     (key),
    .new_current_time_ls_min (a_lsm),
    .new_current_time_ms_min (a_msm),
    .new_current_time_ls_hr  (a_lsh),
    .new_current_time_ms_hr  (a_msh),
    .new_current_time_AM     (a_am),
    .load_new_c              (a_load),
    .entry_error             (a_err),
    .digit_count             (a_cnt)
  );

  time_key_entry #(.TWELVE_HOUR(0), .MIN_DIGITS(3)) u_dut24 (
    .clk                     (clk),
    .reset                   (reset),
    .key_valid               (key_valid),
    .key                     (key),
    .new_current_time_ls_min (b_lsm),
    .new_current_time_ms_min (b_msm),
    .new_current_time_ls_hr  (b_lsh),
    .new_current_time_ms_hr  (b_msh),
    .new_current_time_AM     (b_am),
    .load_new_c              (b_load),
    .entry_error             (b_err),
    .digit_count             (b_cnt)
  );

  // Model: digits held as an hour/minute picture, index 0 = hours tens .. 3 = minutes units.
  int m_d   [2][4];
  int m_cnt [2];
  bit m_am  [2];
  bit m_load[2];
  bit m_err [2];
  bit m_typing[2];  // collecting digits into the current entry
  bit m_failed[2];  // last SET rejected and nothing typed since

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit time_ok(input int m);
    int h = 10 * m_d[m][0] + m_d[m][1];
    if (m_cnt[m] < 3) return 1'b0;
    for (int i = 0; i < 4; i++) if (m_d[m][i] > 9) return 1'b0;
    if (m_d[m][2] > 5) return 1'b0;
    return (m == 0) ? (h >= 1 && h <= 12) : (h <= 23);
  endfunction

  task automatic model_step(input int m);
    int k = int'(key);
    if (!reset) begin
      for (int i = 0; i < 4; i++) m_d[m][i] = 0;
      m_cnt[m] = 0; m_am[m] = (m == 0); m_load[m] = 0; m_err[m] = 0;
      m_typing[m] = 0; m_failed[m] = 0;
      return;
    end
    if (m_load[m]) begin
      m_load[m] = 0; m_cnt[m] = 0; m_typing[m] = 0; m_failed[m] = 0;
      return;
    end
    if (!key_valid) return;
    if (k <= 9) begin
      if (!m_typing[m]) begin
        for (int i = 0; i < 4; i++) m_d[m][i] = 0;
        m_cnt[m] = 0;
      end
      for (int i = 0; i < 3; i++) m_d[m][i] = m_d[m][i+1];
      m_d[m][3] = k;
      m_cnt[m] = (m_cnt[m] + 1 > 4) ? 4 : m_cnt[m] + 1;
      m_err[m] = 0; m_typing[m] = 1; m_failed[m] = 0;
    end else if (k == 10) begin
      if (m == 0) begin
        m_am[m] = !m_am[m];
        if (m_failed[m]) begin
          m_err[m] = 0; m_failed[m] = 0; m_typing[m] = 1;
        end
      end
    end else if (k == 11) begin
      if (m_typing[m] && time_ok(m)) begin
        m_load[m] = 1;
      end else begin
        m_err[m] = 1; m_failed[m] = 1;
      end
      m_typing[m] = 0;
    end else if (k == 12) begin
      for (int i = 0; i < 4; i++) m_d[m][i] = 0;
      m_cnt[m] = 0; m_err[m] = 0; m_typing[m] = 0; m_failed[m] = 0;
    end
  endtask

  task automatic compare_all();
    check("ms_hr12",  32'(a_msh),  32'(m_d[0][0]));
    check("ls_hr12",  32'(a_lsh),  32'(m_d[0][1]));
    check("ms_min12", 32'(a_msm),  32'(m_d[0][2]));
    check("ls_min12", 32'(a_lsm),  32'(m_d[0][3]));
    check("am12",     32'(a_am),   32'(m_am[0]));
    check("load12",   32'(a_load), 32'(m_load[0]));
    check("err12",    32'(a_err),  32'(m_err[0]));
    check("cnt12",    32'(a_cnt),  32'(m_cnt[0]));
    check("ms_hr24",  32'(b_msh),  32'(m_d[1][0]));
    check("ls_hr24",  32'(b_lsh),  32'(m_d[1][1]));
    check("ms_min24", 32'(b_msm),  32'(m_d[1][2]));
    check("ls_min24", 32'(b_lsm),  32'(m_d[1][3]));
    check("am24",     32'(b_am),   32'(m_am[1]));
    check("load24",   32'(b_load), 32'(m_load[1]));
    check("err24",    32'(b_err),  32'(m_err[1]));
    check("cnt24",    32'(b_cnt),  32'(m_cnt[1]));
  endtask

  task automatic tick(input logic rst, input logic kv, input logic [3:0] k);
    @(negedge clk);
    reset = rst; key_valid = kv; key = k;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1 compare_all();
  endtask

  task automatic press(input logic [3:0] k);
    tick(1'b1, 1'b1, k);
  endtask

  function automatic logic [15:0] buf12();
    return {a_msh, a_lsh, a_msm, a_lsm};
  endfunction

  function automatic logic [15:0] buf24();
    return {b_msh, b_lsh, b_msm, b_lsm};
  endfunction

  initial begin
    reset = 1'b0; key_valid = 1'b0; key = 4'h0;

    // Reset held with keys toggling.
    tick(1'b0, 1'b1, 4'h5);
    tick(1'b0, 1'b0, 4'hB);
    tick(1'b1, 1'b0, 4'h0);
    check("rst_buf", 32'(buf12()), 32'h0000);
    check("rst_am",  32'(a_am), 32'd1);
    check("rst_cnt", 32'(a_cnt), 32'd0);

    // 12:42 PM committed.
    press(4'h1); press(4'h2); press(4'h4); press(4'h2); press(4'hA);
    check("am_tog", 32'(a_am), 32'd0);
    press(4'hB);
    check("load_pulse", 32'(a_load), 32'd1);
    check("load_buf",   32'(buf12()), 32'h1242);
    tick(1'b1, 1'b0, 4'h0);
    check("load_end", 32'(a_load), 32'd0);
    check("post_cnt", 32'(a_cnt), 32'd0);
    check("post_buf", 32'(buf12()), 32'h1242);

    // Minutes tens out of range.
    press(4'h9); press(4'h6); press(4'h0); press(4'hB);
    check("min_err",  32'(a_err), 32'd1);
    check("min_buf",  32'(buf12()), 32'h0960);
    check("min_nold", 32'(a_load), 32'd0);
    press(4'h7);
    check("recov_buf", 32'(buf12()), 32'h0007);
    check("recov_err", 32'(a_err), 32'd0);

    // Hour 13: rejected in 12-hour mode, loaded in 24-hour mode.
    press(4'hC);
    press(4'h1); press(4'h3); press(4'h0); press(4'h0); press(4'hB);
    check("h13_err12",  32'(a_err), 32'd1);
    check("h13_load24", 32'(b_load), 32'd1);
    check("h13_buf24",  32'(buf24()), 32'h1300);
    check("h13_am24",   32'(b_am), 32'd0);
    tick(1'b1, 1'b0, 4'h0);

    // Fifth digit shifts the leading one out.
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
    check("shift_buf", 32'(buf12()), 32'h2345);
    check("shift_cnt", 32'(a_cnt), 32'd4);

    // Too few digits, then CLEAR.
    press(4'hC); press(4'h5); press(4'hB);
    check("few_err", 32'(a_err), 32'd1);
    press(4'hC);
    check("clr_buf", 32'(buf12()), 32'h0000);
    check("clr_err", 32'(a_err), 32'd0);
    check("clr_am",  32'(a_am), 32'd0);

    // Key during LOAD is dropped.
    press(4'h1); press(4'h2); press(4'h0); press(4'h0); press(4'hB);
    press(4'h7);
    check("drop_buf", 32'(buf12()), 32'h1200);
    check("drop_cnt", 32'(a_cnt), 32'd0);

    // Reset on the same edge as a valid SET.
    press(4'h1); press(4'h2); press(4'h0); press(4'h0);
    tick(1'b0, 1'b1, 4'hB);
    check("rset_load", 32'(a_load), 32'd0);
    check("rset_buf",  32'(buf12()), 32'h0000);
    check("rset_am",   32'(a_am), 32'd1);

    // Random traffic; small digits are favoured so that valid times come up often.
    for (int n = 0; n < 4000; n++) begin
      logic       r_rst;
      logic       r_kv;
      logic [3:0] r_key;
      int         sel;
      r_rst = ($urandom_range(0, 99) != 0);
      r_kv  = ($urandom_range(0, 3) != 0);
      sel   = $urandom_range(0, 99);
      if (sel < 35)      r_key = 4'($urandom_range(0, 2));
      else if (sel < 65) r_key = 4'($urandom_range(0, 9));
      else if (sel < 75) r_key = 4'hA;
      else if (sel < 88) r_key = 4'hB;
      else if (sel < 94) r_key = 4'hC;
      else               r_key = 4'($urandom_range(13, 15));
      tick(r_rst, r_kv, r_key);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
